// File: rtl/chacha_word_streamer.sv
`default_nettype none
// ============================================================================
// Module   : chacha_word_streamer
// Purpose  : Requests ChaCha 512-bit blocks, buffers up to DEPTH of them and
//            streams them as 32-bit words. `define RNG_REPCNT_EN adds a
//            repetition-count health test on the popped words.
// Revision : 1.0  initial release
// ============================================================================
module chacha_word_streamer #(
  parameter int DEPTH     = 2,
  parameter int REP_LIMIT = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic         gen_valid,
  input  logic [511:0] blk_in,
  input  logic         blk_intr,
  output logic [31:0]  rnd_data,
  output logic         rnd_valid,
  input  logic         rnd_ready,
  output logic [31:0]  blk_count,
  output logic         ovf_err,
  output logic         rep_err
);

  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int FILL_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0]  C_PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [FILL_W-1:0] C_FULL     = FILL_W'(DEPTH);

  if ((DEPTH < 1) || (DEPTH > 2) || (REP_LIMIT < 1)) begin : g_param_check
    $error("chacha_word_streamer: unsupported DEPTH or REP_LIMIT");
  end

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_REQ  = 2'd1,
    R_WAIT = 2'd2
  } req_state_t;

  req_state_t        r_state, w_state_n;
  logic              r_outstanding, w_outstanding_n;

  logic [511:0]      r_slot [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr, w_wr_ptr_n;
  logic [PTR_W-1:0]  r_rd_ptr, w_rd_ptr_n;
  logic [FILL_W-1:0] r_fill, w_fill_n;
  logic [3:0]        r_idx, w_idx_n;
  logic              r_rnd_valid;
  logic [31:0]       r_rnd_data, w_rnd_data_n;
  logic [31:0]       r_blk_count;
  logic              r_ovf_err;
  logic              r_rep_err, w_rep_err_n;

  logic              w_pop, w_pop_last, w_capture, w_drop, w_bypass;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == C_PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  // ---------------------------------------------------------------- request FSM
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= R_IDLE;
      r_outstanding <= 1'b0;
    end else begin
      r_state       <= w_state_n;
      r_outstanding <= w_outstanding_n;
    end
  end

  always_comb begin
    w_state_n       = r_state;
    w_outstanding_n = r_outstanding;
    gen_valid       = 1'b0;
    case (r_state)
      R_IDLE: begin
        if (en && !r_outstanding && (r_fill < C_FULL)) begin
          w_state_n = R_REQ;
        end
      end
      R_REQ: begin
        gen_valid       = 1'b1;
        w_outstanding_n = 1'b1;
        w_state_n       = R_WAIT;
      end
      R_WAIT: begin
        if (blk_intr) begin
          w_outstanding_n = 1'b0;
          w_state_n       = R_IDLE;
        end
      end
      default: w_state_n = R_IDLE;
    endcase
  end

  // ------------------------------------------------------------ buffer control
  always_comb begin
    w_pop      = r_rnd_valid & rnd_ready;
    w_pop_last = w_pop & (r_idx == 4'hF);
    w_capture  = blk_intr & (r_fill < C_FULL);
    w_drop     = blk_intr & (r_fill == C_FULL);

    w_idx_n    = w_pop ? (r_idx + 4'd1) : r_idx;
    w_rd_ptr_n = w_pop_last ? ptr_inc(r_rd_ptr) : r_rd_ptr;
    w_wr_ptr_n = w_capture ? ptr_inc(r_wr_ptr) : r_wr_ptr;

    w_fill_n = r_fill;
    if (w_capture && !w_pop_last) begin
      w_fill_n = r_fill + 1'b1;
    end else if (!w_capture && w_pop_last) begin
      w_fill_n = r_fill - 1'b1;
    end

    // A block landing in the slot about to be read is forwarded straight from
    // blk_in so the first word appears one cycle after blk_intr.
    w_bypass     = w_capture & (r_wr_ptr == w_rd_ptr_n);
    w_rnd_data_n = w_bypass ? blk_in[{w_idx_n, 5'd0} +: 32]
                            : r_slot[w_rd_ptr_n][{w_idx_n, 5'd0} +: 32];
  end

  always_ff @(posedge clk) begin
    if (!rst && w_capture) begin
      r_slot[r_wr_ptr] <= blk_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_fill      <= '0;
      r_idx       <= '0;
      r_rnd_valid <= 1'b0;
      r_rnd_data  <= '0;
      r_blk_count <= '0;
      r_ovf_err   <= 1'b0;
      r_rep_err   <= 1'b0;
    end else begin
      r_wr_ptr    <= w_wr_ptr_n;
      r_rd_ptr    <= w_rd_ptr_n;
      r_fill      <= w_fill_n;
      r_idx       <= w_idx_n;
      r_rnd_valid <= (w_fill_n != '0) & ~w_rep_err_n;
      r_rnd_data  <= w_rnd_data_n;
      r_blk_count <= r_blk_count + (w_capture ? 32'd1 : 32'd0);
      r_ovf_err   <= r_ovf_err | w_drop;
      r_rep_err   <= w_rep_err_n;
    end
  end

  // ----------------------------------------------------- repetition health test
`ifdef RNG_REPCNT_EN
  localparam int RUN_W = $clog2(REP_LIMIT + 1);
  localparam logic [RUN_W-1:0] C_REP_LIMIT = RUN_W'(REP_LIMIT);

  logic [31:0]      r_prev_word;
  logic             r_have_prev;
  logic [RUN_W-1:0] r_run, w_run_n;

  always_comb begin
    w_run_n     = r_run;
    w_rep_err_n = r_rep_err;
    if (w_pop) begin
      if (r_have_prev && (r_rnd_data == r_prev_word)) begin
        w_run_n = r_run + 1'b1;
      end else begin
        w_run_n = RUN_W'(1);
      end
      if (w_run_n == C_REP_LIMIT) begin
        w_rep_err_n = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_prev_word <= '0;
      r_have_prev <= 1'b0;
      r_run       <= '0;
    end else if (w_pop) begin
      r_prev_word <= r_rnd_data;
      r_have_prev <= 1'b1;
      r_run       <= w_run_n;
    end
  end
`else
  assign w_rep_err_n = 1'b0;
`endif

  assign rnd_data  = r_rnd_data;
  assign rnd_valid = r_rnd_valid;
  assign blk_count = r_blk_count;
  assign ovf_err   = r_ovf_err;
  assign rep_err   = r_rep_err;

endmodule
`default_nettype wire
